// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants, slice-width helpers and types for the pipelined adder
package adder_pkg;

    // Default configuration: drop-in for the 14-bit combinational adder
    localparam int DEF_WIDTH  = 14;
    localparam int DEF_STAGES = 2;

    typedef logic [7:0] stage_idx_t;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    function automatic int clog2_int(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Width of every slice except possibly the last
    function automatic int slice_width(input int width, input int stages);
        return ceil_div(width, stages);
    endfunction

    // The last slice carries whatever bits remain after the full-width slices
    function automatic int last_slice_width(input int width, input int stages);
        return width - (stages - 1) * slice_width(width, stages);
    endfunction

    localparam int DEF_SW     = slice_width(DEF_WIDTH, DEF_STAGES);
    localparam int DEF_LAST_W = last_slice_width(DEF_WIDTH, DEF_STAGES);
    localparam int DEF_IDX_W  = clog2_int(DEF_STAGES);

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - one registered slice of the pipelined adder (sum slice + carry out)
module adder_slice #(
    parameter int SLICE_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_ci,
    output logic [SLICE_W-1:0] o_sum,
    output logic               o_co
);

    logic [SLICE_W-1:0] r_sum;
    logic               r_co;

    // Register the slice sum and its carry; hold while the pipeline is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
            r_co  <= 1'b0;
        end else if (i_en) begin
            {r_co, r_sum} <= {1'b0, i_a} + {1'b0, i_b} + (SLICE_W + 1)'(i_ci);
        end
    end

    assign o_sum = r_sum;
    assign o_co  = r_co;

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-deep sliced adder with valid/ready handshake; ADDER_SUB_EN adds a subtract port
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Operands are zero-padded to STAGES*SW bits so every slice is SW wide;
    // the padding bits are constant zero, so the carry out of bit WIDTH-1
    // lands in padded result bit WIDTH.
    localparam int SW = slice_width(WIDTH, STAGES);
    localparam int PW = SW * STAGES;

    logic              w_adv;
    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  w_b_eff;
    logic              w_cin_eff;
    logic [PW-1:0]     w_a_pad;
    logic [PW-1:0]     w_b_pad;
    logic [PW:0]       w_res;

    // Subtract is a + ~b + 1, so cout becomes NOT borrow
`ifdef ADDER_SUB_EN
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub | cin;
`else
    assign w_b_eff   = b;
    assign w_cin_eff = cin;
`endif

    assign w_a_pad = PW'(a);
    assign w_b_pad = PW'(w_b_eff);

    // Global stall: every stage moves together or not at all
    assign w_adv     = ~r_valid[STAGES-1] | out_ready;
    assign in_ready  = w_adv & ~rst;
    assign out_valid = r_valid[STAGES-1];

    // Valid bits shift with the data; bubbles stay in place as zeros
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_adv) begin
            r_valid[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            // Operand bits not yet consumed by earlier stages
            localparam int RW = PW - k * SW;

            logic [RW-1:0]         w_a;
            logic [RW-1:0]         w_b;
            logic                  w_ci;
            logic [SW-1:0]         w_s;
            logic                  w_co;
            // Sum bits of this beat completed so far, aligned to this stage's output
            logic [(k+1)*SW-1:0]   w_acc;

            if (k == 0) begin : g_first
                assign w_a   = w_a_pad;
                assign w_b   = w_b_pad;
                assign w_ci  = w_cin_eff;
                assign w_acc = w_s;
            end else begin : g_skew
                logic [RW-1:0]     r_a;
                logic [RW-1:0]     r_b;
                logic [k*SW-1:0]   r_lo;

                // Delay upper operand slices and de-skew lower sum bits by one stage
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_a  <= '0;
                        r_b  <= '0;
                        r_lo <= '0;
                    end else if (w_adv) begin
                        r_a  <= g_stage[k-1].w_a[RW+SW-1:SW];
                        r_b  <= g_stage[k-1].w_b[RW+SW-1:SW];
                        r_lo <= g_stage[k-1].w_acc;
                    end
                end

                assign w_a   = r_a;
                assign w_b   = r_b;
                assign w_ci  = g_stage[k-1].w_co;
                assign w_acc = {w_s, r_lo};
            end

            adder_slice #(
                .SLICE_W (SW)
            ) u_slice (
                .clk   (clk),
                .rst   (rst),
                .i_en  (w_adv),
                .i_a   (w_a[SW-1:0]),
                .i_b   (w_b[SW-1:0]),
                .i_ci  (w_ci),
                .o_sum (w_s),
                .o_co  (w_co)
            );
        end
    endgenerate

    assign w_res = {g_stage[STAGES-1].w_co, g_stage[STAGES-1].w_acc};
    assign sum   = w_res[WIDTH-1:0];
    assign cout  = w_res[WIDTH];

endmodule
